// File: rtl/lru_victim_sequencer.sv
// Per-set LRU age tracker with a sequential victim scan.
// One way is examined per cycle through a single shared age comparator.
module lru_victim_sequencer #(
  parameter int unsigned WAYS     = 4,
  parameter int unsigned WAY_BITS = 2,
  parameter int unsigned SETS     = 8,
  parameter int unsigned SET_BITS = 3,
  parameter int unsigned AGE_BITS = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                acc_valid,
  input  logic [SET_BITS-1:0] acc_set,
  input  logic [WAY_BITS-1:0] acc_way,
  input  logic                vic_req,
  input  logic [SET_BITS-1:0] vic_set,
  output logic                vic_busy,
  output logic                vic_valid,
  output logic [WAY_BITS-1:0] vic_way
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [AGE_BITS-1:0] AGE_MAX  = '1;
  localparam logic [WAY_BITS-1:0] LAST_IDX = WAY_BITS'(WAYS - 1);

  logic [AGE_BITS-1:0] age_q [SETS][WAYS];
  logic [AGE_BITS-1:0] age_d [SETS][WAYS];

  logic [1:0]          state_q, state_d;
  logic [SET_BITS-1:0] sset_q, sset_d;
  logic [WAY_BITS-1:0] idx_q, idx_d;
  logic [AGE_BITS-1:0] best_age_q, best_age_d;
  logic [WAY_BITS-1:0] best_way_q, best_way_d;
  logic [WAY_BITS-1:0] vic_way_q, vic_way_d;

  logic                acc_ok;
  logic [AGE_BITS-1:0] acc_age;
  logic [AGE_BITS-1:0] cur_age;
  logic                age_gt;
  logic                scan_hit;

  assign acc_ok  = acc_valid && (32'(acc_way) < WAYS);
  assign acc_age = age_q[acc_set][acc_way];

  // Ways younger than the accessed one age by one; the accessed way becomes youngest.
  always_comb begin
    age_d = age_q;
    if (acc_ok) begin
      for (int w = 0; w < WAYS; w++) begin
        if (WAY_BITS'(w) == acc_way) begin
          age_d[acc_set][w] = '0;
        end else if ((age_q[acc_set][w] < acc_age) && (age_q[acc_set][w] != AGE_MAX)) begin
          age_d[acc_set][w] = age_q[acc_set][w] + 1'b1;
        end
      end
    end
  end

  // The only age comparator used by the scan.
  assign cur_age  = age_q[sset_q][idx_q];
  assign age_gt   = cur_age > best_age_q;
  assign scan_hit = acc_ok && (acc_set == sset_q);

  always_comb begin
    state_d    = state_q;
    sset_d     = sset_q;
    idx_d      = idx_q;
    best_age_d = best_age_q;
    best_way_d = best_way_q;
    vic_way_d  = vic_way_q;
    case (state_q)
      IDLE: begin
        if (vic_req) begin
          sset_d  = vic_set;
          idx_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (scan_hit) begin
          // Ages of the scanned set moved under us: start over.
          idx_d = '0;
        end else begin
          if ((idx_q == '0) || age_gt) begin
            best_age_d = cur_age;
            best_way_d = idx_q;
          end
          if (idx_q == LAST_IDX) begin
            vic_way_d = best_way_d;
            state_d   = DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          age_q[s][w] <= AGE_BITS'(w);
        end
      end
    end else begin
      age_q <= age_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      sset_q     <= '0;
      idx_q      <= '0;
      best_age_q <= '0;
      best_way_q <= '0;
      vic_way_q  <= '0;
    end else begin
      state_q    <= state_d;
      sset_q     <= sset_d;
      idx_q      <= idx_d;
      best_age_q <= best_age_d;
      best_way_q <= best_way_d;
      vic_way_q  <= vic_way_d;
    end
  end

  assign vic_busy  = (state_q == SCAN) || (state_q == DONE);
  assign vic_valid = (state_q == DONE);
  assign vic_way   = vic_way_q;

endmodule

// File: tb/tb_lru_victim_sequencer.sv
// Scoreboard bench for lru_victim_sequencer: a per-cycle driver feeds an
// age/latency reference model, a negedge monitor checks what the DUT presents.
module tb_lru_victim_sequencer;

  localparam int WAYS = 4;
  localparam int SETS = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       acc_valid;
  logic [2:0] acc_set;
  logic [1:0] acc_way;
  logic       vic_req;
  logic [2:0] vic_set;
  logic       vic_busy;
  logic       vic_valid;
  logic [1:0] vic_way;

  lru_victim_sequencer #(
    .WAYS(4), .WAY_BITS(2), .SETS(8), .SET_BITS(3), .AGE_BITS(3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .acc_valid(acc_valid),
    .acc_set  (acc_set),
    .acc_way  (acc_way),
    .vic_req  (vic_req),
    .vic_set  (vic_set),
    .vic_busy (vic_busy),
    .vic_valid(vic_valid),
    .vic_way  (vic_way)
  );

  always #5 clk = ~clk;

  // Reference model: ages per set, busy cycles still to come, scanned set.
  int age_m [SETS][WAYS];
  int busy_left = 0;
  int sset_m = 0;
  int exp_q[$];

  int n_checks = 0;
  int n_pass = 0;
  int last_way = -1;
  int busy_run = 0;
  int last_len = 0;
  int pulses = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic void model_reset();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) age_m[s][w] = w;
    busy_left = 0;
    exp_q.delete();
  endfunction

  // LRU rule: younger ways age by one (cap 7), accessed way becomes 0.
  function automatic void model_access(input int s, input int aw);
    int a;
    a = age_m[s][aw];
    for (int w = 0; w < WAYS; w++) begin
      if (w == aw) age_m[s][w] = 0;
      else if (age_m[s][w] < a && age_m[s][w] < 7) age_m[s][w] = age_m[s][w] + 1;
    end
  endfunction

  // Oldest way, lowest index wins ties.
  function automatic int model_victim(input int s);
    int best;
    best = 0;
    for (int w = 1; w < WAYS; w++)
      if (age_m[s][w] > age_m[s][best]) best = w;
    return best;
  endfunction

  // Drive one cycle of stimulus, then advance the model across the clock edge.
  task automatic step(input bit av, input int as, input int aw, input bit rq, input int rs);
    bit same;
    int nb;
    @(negedge clk);
    #1;
    acc_valid = av;
    acc_set   = 3'(as);
    acc_way   = 2'(aw);
    vic_req   = rq;
    vic_set   = 3'(rs);
    @(posedge clk);
    #1;
    same = av && (aw < WAYS) && (as == sset_m);
    if (busy_left == 0) begin
      nb = 0;
      if (rq) begin
        nb = WAYS + 1;
        sset_m = rs;
      end
    end else if (busy_left >= 2 && same) begin
      nb = WAYS + 1;
    end else begin
      nb = busy_left - 1;
    end
    if (av && aw < WAYS) model_access(as, aw);
    busy_left = nb;
    if (nb == 1) exp_q.push_back(model_victim(sset_m));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0, 0);
  endtask

  task automatic reset_now();
    @(negedge clk);
    #1;
    acc_valid = 1'b0;
    vic_req   = 1'b0;
    reset     = 1'b1;
    model_reset();
    #1;
    chk("reset_busy_drop", int'(vic_busy), 0);
    chk("reset_valid_drop", int'(vic_valid), 0);
    @(negedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Monitor: cycle-accurate busy/valid against the model, victim from the queue.
  always @(negedge clk) begin
    chk("vic_busy", int'(vic_busy), int'(busy_left > 0));
    chk("vic_valid", int'(vic_valid), int'(busy_left == 1));
    if (vic_busy) busy_run++;
    else busy_run = 0;
    if (vic_valid) begin
      pulses++;
      last_len = busy_run;
      last_way = int'(vic_way);
      if (exp_q.size() == 0) chk("unexpected_valid", 1, 0);
      else chk("vic_way", int'(vic_way), exp_q.pop_front());
    end
  end

  initial begin
    int p0;
    reset     = 1'b1;
    acc_valid = 1'b0;
    acc_set   = '0;
    acc_way   = '0;
    vic_req   = 1'b0;
    vic_set   = '0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("reset_vic_way", int'(vic_way), 0);
    chk("reset_vic_busy", int'(vic_busy), 0);
    chk("reset_vic_valid", int'(vic_valid), 0);
    reset = 1'b0;

    // Fresh set: oldest is way 3, five busy cycles.
    step(1'b0, 0, 0, 1'b1, 2);
    idle(8);
    chk("t1_way", last_way, 3);
    chk("t1_latency", last_len, 5);
    chk("t1_hold", int'(vic_way), 3);

    // Accesses to ways 3,2,1 leave way 0 oldest.
    step(1'b1, 5, 3, 1'b0, 0);
    step(1'b1, 5, 2, 1'b0, 0);
    step(1'b1, 5, 1, 1'b0, 0);
    step(1'b0, 0, 0, 1'b1, 5);
    idle(8);
    chk("t2_way", last_way, 0);

    // Same-cycle access and request: scan sees updated ages.
    step(1'b1, 1, 3, 1'b1, 1);
    idle(8);
    chk("t3_way", last_way, 2);
    chk("t3_latency", last_len, 5);

    // Same-set access in scan cycle 2 restarts the scan.
    step(1'b0, 0, 0, 1'b1, 4);
    step(1'b0, 0, 0, 1'b0, 0);
    step(1'b1, 4, 2, 1'b0, 0);
    idle(10);
    chk("t4_way", last_way, 3);
    chk("t4_latency", last_len, 7);

    // Other-set access does not disturb the scan.
    step(1'b0, 0, 0, 1'b1, 4);
    step(1'b0, 0, 0, 1'b0, 0);
    step(1'b1, 0, 2, 1'b0, 0);
    idle(8);
    chk("t4b_way", last_way, 3);
    chk("t4b_latency", last_len, 5);

    // Request while busy is dropped.
    p0 = pulses;
    step(1'b0, 0, 0, 1'b1, 2);
    step(1'b0, 0, 0, 1'b0, 0);
    step(1'b0, 0, 0, 1'b1, 3);
    idle(10);
    chk("t5_one_pulse", pulses - p0, 1);

    // Reset mid-scan: no pulse, ages reinitialised.
    p0 = pulses;
    step(1'b0, 0, 0, 1'b1, 5);
    idle(2);
    reset_now();
    idle(4);
    chk("t6_no_pulse", pulses - p0, 0);
    step(1'b0, 0, 0, 1'b1, 5);
    idle(8);
    chk("t6_way", last_way, 3);

    // Random traffic on a few sets to provoke restarts and ignored requests.
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 2) == 0), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
           ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)));
    end
    idle(20);
    chk("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
